// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the MAC operand sequencer slice.
package mac_pkg;

    localparam int DATA_W          = 16;
    localparam int ACC_W           = 32;
    // Must track the pipeline depth of the downstream MAC.
    localparam int MAC_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous DEPTH-entry FIFO with full/empty flags and combinational read data.
module mac_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on each pointer distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds operand pairs from a FIFO to the MAC per job and returns the accumulator.
// Optional starvation abort: define MACSEQ_TIMEOUT_EN.
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = MAC_LAT_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mac_clr,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  acc_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_err,
    output logic              busy
);

    localparam int LAT_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT);

    seq_state_t              state;
    seq_state_t              state_nx;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W:0]          issued;
    logic [LAT_W-1:0]        lat_cnt;
    logic [2*DATA_W-1:0]     fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    lat_done;
    logic                    last_pop;

    assign in_ready  = !fifo_full;
    assign pop       = (state == STREAM) && !fifo_empty;
    assign lat_done  = (lat_cnt == LAT_W'(MAC_LAT - 1));
    assign last_pop  = pop && ((issued + 1'b1) == {1'b0, len_q});
    assign mac_clr   = (state == CLEAR);
    assign busy      = (state != IDLE);
    assign res_valid = (state == HOLD);

    mac_operand_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !fifo_full),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MACSEQ_TIMEOUT_EN
    localparam int STV_W = $clog2(TIMEOUT + 1);

    logic [STV_W-1:0] starve;
    logic             starved;
    logic             abort_q;

    assign starved = (state == STREAM) && fifo_empty && (starve == STV_W'(TIMEOUT - 1));
    assign res_err = (state == HOLD) && abort_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve  <= '0;
            abort_q <= 1'b0;
        end else if (state == CLEAR) begin
            starve  <= '0;
            abort_q <= 1'b0;
        end else if (state == STREAM) begin
            if (pop) starve <= '0;
            else     starve <= starve + 1'b1;
            if (starved) abort_q <= 1'b1;
        end
    end
`else
    logic starved;

    assign starved = 1'b0;
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = (len_q == '0) ? DRAIN : STREAM;
            STREAM:  if (last_pop || starved) state_nx = DRAIN;
            DRAIN:   if (lat_done) state_nx = HOLD;
            HOLD:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            issued   <= '0;
            lat_cnt  <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            res_data <= '0;
        end else begin
            // Empty or non-STREAM cycles feed zeros so the accumulator is unaffected.
            mac_a <= pop ? fifo_dout[2*DATA_W-1:DATA_W] : '0;
            mac_b <= pop ? fifo_dout[DATA_W-1:0] : '0;
            case (state)
                IDLE: begin
                    if (start) len_q <= vec_len;
                    issued  <= '0;
                    lat_cnt <= '0;
                end
                STREAM: if (pop) issued <= issued + 1'b1;
                DRAIN: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_done) res_data <= acc_in;
                end
                default: ;
            endcase
        end
    end

endmodule
